seg7_scan_display: RTL and testbench



---
 rtl/seg7_scan_display.sv | 152 +++++++++++++++
 tb/tb_seg7_scan_display.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/seg7_scan_display.sv
// rtl/seg7_scan_display.sv - 8-digit multiplexed seven-segment driver with hex/decimal display.
// Decimal values go through a one-bit-per-cycle double-dabble engine before being committed.
module seg7_scan_display #(
  parameter int DATA_WIDTH = 32,
  parameter int SCAN_DIV   = 100000,
  parameter bit BLANK_LZ   = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  load,
  input  logic                  dec_mode,
  output logic                  busy,
  output logic                  ovf,
  output logic [7:0]            an,
  output logic [6:0]            seg,
  output logic                  dp
);

  localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

  typedef enum logic [1:0] {IDLE, CONV, COMMIT} state_t;

  state_t           state_q;
  logic [31:0]      disp_q;
  logic [31:0]      shift_q;
  logic [39:0]      bcd_q;
  logic [4:0]       iter_q;
  logic             busy_q;
  logic             ovf_q;
  logic [DIV_W-1:0] div_q;
  logic [2:0]       idx_q;
  logic [7:0]       an_q;
  logic [6:0]       seg_q;
  logic             dp_q;

  logic [39:0]      bcd_adj;
  logic [71:0]      dd_next;
  logic [7:0]       lz_blank;
  logic             nz_above;
  logic [3:0]       cur_nib;
  logic [6:0]       seg_d;

  function automatic logic [6:0] hex7(input logic [3:0] v);
    case (v)
      4'h0: hex7 = 7'b1000000;
      4'h1: hex7 = 7'b1111001;
      4'h2: hex7 = 7'b0100100;
      4'h3: hex7 = 7'b0110000;
      4'h4: hex7 = 7'b0011001;
      4'h5: hex7 = 7'b0010010;
      4'h6: hex7 = 7'b0000010;
      4'h7: hex7 = 7'b1111000;
      4'h8: hex7 = 7'b0000000;
      4'h9: hex7 = 7'b0010000;
      4'hA: hex7 = 7'b0001000;
      4'hB: hex7 = 7'b0000011;
      4'hC: hex7 = 7'b1000110;
      4'hD: hex7 = 7'b0100001;
      4'hE: hex7 = 7'b0000110;
      default: hex7 = 7'b0001110;
    endcase
  endfunction

  // Add-3 correction on every BCD nibble, then shift the combined {bcd,shift} register left.
  always_comb begin
    bcd_adj = bcd_q;
    for (int i = 0; i < 10; i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
    end
    dd_next = {bcd_adj, shift_q} << 1;
  end

  always_comb begin
    lz_blank = 8'h00;
    nz_above = 1'b0;
    for (int k = 7; k >= 1; k--) begin
      nz_above    = nz_above | (disp_q[4*k +: 4] != 4'h0);
      lz_blank[k] = ~nz_above;
    end
    cur_nib = disp_q[{idx_q, 2'b00} +: 4];
    seg_d   = (BLANK_LZ && lz_blank[idx_q]) ? 7'h7F : hex7(cur_nib);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      disp_q  <= '0;
      shift_q <= '0;
      bcd_q   <= '0;
      iter_q  <= '0;
      busy_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (load && !dec_mode) begin
            disp_q <= data_in;
            ovf_q  <= 1'b0;
          end else if (load) begin
            shift_q <= data_in;
            bcd_q   <= '0;
            iter_q  <= '0;
            busy_q  <= 1'b1;
            state_q <= CONV;
          end
        end
        CONV: begin
          bcd_q   <= dd_next[71:32];
          shift_q <= dd_next[31:0];
          iter_q  <= iter_q + 5'd1;
          if (iter_q == 5'd31) state_q <= COMMIT;
        end
        COMMIT: begin
          disp_q  <= bcd_q[31:0];
          ovf_q   <= (bcd_q[39:32] != 8'h00);
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Outputs are registered from the index, so an/seg/dp move together one cycle after it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_q <= '0;
      idx_q <= '0;
      an_q  <= 8'hFF;
      seg_q <= 7'h7F;
      dp_q  <= 1'b1;
    end else begin
      if (div_q == DIV_W'(SCAN_DIV - 1)) begin
        div_q <= '0;
        idx_q <= idx_q + 3'd1;
      end else begin
        div_q <= div_q + 1'b1;
      end
      an_q  <= ~(8'h01 << idx_q);
      seg_q <= seg_d;
      dp_q  <= ~((idx_q == 3'd7) && ovf_q);
    end
  end

  assign busy = busy_q;
  assign ovf  = ovf_q;
  assign an   = an_q;
  assign seg  = seg_q;
  assign dp   = dp_q;

endmodule

// File: tb/tb_seg7_scan_display.sv
// tb/tb_seg7_scan_display.sv - scoreboard bench for seg7_scan_display.
// Expected frames come from plain div/mod arithmetic; a monitor compares each full scan sweep.
module tb_seg7_scan_display;

  localparam int SCAN_DIV = 4;

  typedef struct packed {
    logic [55:0] segs;
    logic [7:0]  dps;
    logic        ovf;
  } frame_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] data_in = '0;
  logic        load = 1'b0;
  logic        dec_mode = 1'b0;
  logic        busy, ovf, dp;
  logic [7:0]  an;
  logic [6:0]  seg;

  int checks = 0;
  int errors = 0;
  int pushed = 0;
  int frames_done = 0;
  frame_t sb_q[$];

  always #5 clk = ~clk;

  seg7_scan_display #(.DATA_WIDTH(32), .SCAN_DIV(SCAN_DIV), .BLANK_LZ(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .data_in(data_in), .load(load), .dec_mode(dec_mode),
    .busy(busy), .ovf(ovf), .an(an), .seg(seg), .dp(dp)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [6:0] seg_of(input logic [3:0] d);
    case (d)
      4'h0: return 7'b1000000;  4'h1: return 7'b1111001;
      4'h2: return 7'b0100100;  4'h3: return 7'b0110000;
      4'h4: return 7'b0011001;  4'h5: return 7'b0010010;
      4'h6: return 7'b0000010;  4'h7: return 7'b1111000;
      4'h8: return 7'b0000000;  4'h9: return 7'b0010000;
      4'hA: return 7'b0001000;  4'hB: return 7'b0000011;
      4'hC: return 7'b1000110;  4'hD: return 7'b0100001;
      4'hE: return 7'b0000110;  default: return 7'b0001110;
    endcase
  endfunction

  function automatic frame_t make_frame(input logic [31:0] v, input bit dec);
    frame_t f;
    int d[8];
    int top;
    longint unsigned x, p;
    x = longint'(v);
    p = 1;
    for (int k = 0; k < 8; k++) begin
      d[k] = dec ? int'((x / p) % 10) : int'((x >> (4 * k)) & 15);
      p = p * 10;
    end
    top = 0;
    for (int k = 0; k < 8; k++) if (d[k] != 0) top = k;
    f.ovf = dec && (x > 64'd99999999);
    for (int k = 0; k < 8; k++) begin
      f.segs[7*k +: 7] = (k > top) ? 7'h7F : seg_of(4'(d[k]));
      f.dps[k] = !(k == 7 && f.ovf);
    end
    return f;
  endfunction

  initial begin : monitor
    logic [7:0] an_prev;
    logic [7:0] cur;
    logic [7:0] exp_an;
    frame_t f;
    int dwell;
    an_prev = 8'hFF;
    forever begin
      @(negedge clk);
      if (sb_q.size() != 0 && an == 8'hFE && an_prev != 8'hFE) begin
        f = sb_q.pop_front();
        check("ovf", 64'(ovf), 64'(f.ovf));
        for (int k = 0; k < 8; k++) begin
          cur = an;
          exp_an = ~(8'h01 << k);
          check($sformatf("an[%0d]", k), 64'(an), 64'(exp_an));
          check($sformatf("seg[%0d]", k), 64'(seg), 64'(f.segs[7*k +: 7]));
          check($sformatf("dp[%0d]", k), 64'(dp), 64'(f.dps[k]));
          dwell = 0;
          while (an == cur && dwell < 64) begin
            dwell++;
            @(negedge clk);
          end
          check($sformatf("dwell[%0d]", k), 64'(dwell), 64'(SCAN_DIV));
        end
        frames_done++;
      end
      an_prev = an;
    end
  end

  task automatic finish_now();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  endtask

  task automatic wait_frames();
    int t = 0;
    while (frames_done < pushed && t < 400) begin
      @(negedge clk);
      t++;
    end
    if (frames_done < pushed) begin
      checks++;
      errors++;
      $display("FAIL frame_timeout: got %0d frames expected %0d", frames_done, pushed);
      finish_now();
    end
  endtask

  task automatic expect_frame(input frame_t f);
    @(posedge clk);
    #1;
    sb_q.push_back(f);
    pushed++;
    wait_frames();
  endtask

  task automatic pulse(input logic [31:0] v, input bit dec);
    @(negedge clk);
    data_in = v;
    dec_mode = dec;
    load = 1'b1;
    @(negedge clk);
    load = 1'b0;
  endtask

  task automatic wait_busy(input string name, input int inject_at, input logic [31:0] iv);
    int cnt = 0;
    while (busy && cnt < 200) begin
      if (cnt == inject_at) begin
        data_in = iv;
        dec_mode = 1'b1;
        load = 1'b1;
      end else begin
        load = 1'b0;
      end
      cnt++;
      @(negedge clk);
    end
    load = 1'b0;
    check(name, 64'(cnt), 64'd33);
  endtask

  task automatic do_load(input logic [31:0] v, input bit dec);
    bit saw;
    pulse(v, dec);
    if (dec) begin
      wait_busy("busy_len", -1, '0);
    end else begin
      saw = 1'b0;
      repeat (40) begin
        saw |= busy;
        @(negedge clk);
      end
      check("hex_busy", 64'(saw), 64'd0);
    end
    expect_frame(make_frame(v, dec));
  endtask

  initial begin : stimulus
    logic [31:0] v;
    bit dec;
    #12;
    check("rst_an", 64'(an), 64'hFF);
    check("rst_seg", 64'(seg), 64'h7F);
    check("rst_dp", 64'(dp), 64'd1);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_ovf", 64'(ovf), 64'd0);
    sb_q.push_back(make_frame(32'd0, 1'b0));
    pushed++;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("first_an", 64'(an), 64'hFE);
    wait_frames();

    do_load(32'h1234ABCD, 1'b0);
    do_load(32'd12345678, 1'b1);
    do_load(32'hFFFFFFFF, 1'b1);
    do_load(32'h00000F00, 1'b0);

    pulse(32'd5, 1'b1);
    wait_busy("busy_ignored", 2, 32'd9);
    repeat (40) @(negedge clk);
    check("no_second_conv", 64'(busy), 64'd0);
    expect_frame(make_frame(32'd5, 1'b1));

    do_load(32'hFFFFFFFF, 1'b1);
    pulse(32'd87654321, 1'b1);
    repeat (9) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("arst_busy", 64'(busy), 64'd0);
    check("arst_an", 64'(an), 64'hFF);
    check("arst_seg", 64'(seg), 64'h7F);
    check("arst_dp", 64'(dp), 64'd1);
    check("arst_ovf", 64'(ovf), 64'd0);
    sb_q.push_back(make_frame(32'd0, 1'b0));
    pushed++;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    wait_frames();
    do_load(32'd87654321, 1'b1);

    for (int i = 0; i < 6; i++) begin
      v = ($urandom_range(0, 2) == 0) ? 32'($urandom_range(0, 9999)) : 32'($urandom);
      dec = 1'($urandom_range(0, 1));
      do_load(v, dec);
    end

    finish_now();
  end

endmodule
